// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, PC step and ALU operation codes.
package cpu_pkg;

  localparam int unsigned PC_WIDTH   = 32;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned ALUOP_W    = 3;

  localparam logic [ALUOP_W-1:0] ALU_FWD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;

endpackage

// File: rtl/alu_pc_exec_unit_if.sv
// Execute-stage bus: PC control from flow logic, operands from regfile/decoder, results out.
interface alu_pc_exec_unit_if;
  import cpu_pkg::*;

  logic                  PC_WE;
  logic [PC_WIDTH-1:0]   PC_NEXT;
  logic [PC_WIDTH-1:0]   PC;
  logic [PC_WIDTH-1:0]   PC_INC;
  logic [DATA_WIDTH-1:0] DATA1;
  logic [DATA_WIDTH-1:0] DATA2;
  logic [DATA_WIDTH-1:0] IMM;
  logic                  NEGATE;
  logic                  IMM_SEL;
  logic [ALUOP_W-1:0]    ALUOP;
  logic [DATA_WIDTH-1:0] RESULT;
  logic                  ZERO;

  modport master (
    output PC_WE, PC_NEXT, DATA1, DATA2, IMM, NEGATE, IMM_SEL, ALUOP,
    input  PC, PC_INC, RESULT, ZERO
  );

  modport slave (
    input  PC_WE, PC_NEXT, DATA1, DATA2, IMM, NEGATE, IMM_SEL, ALUOP,
    output PC, PC_INC, RESULT, ZERO
  );

endinterface

// File: rtl/alu8_core.sv
// 8-bit ALU: operand-2 negate/immediate select, op decode and zero flag. Purely combinational.
module alu8_core
  import cpu_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic [DATA_WIDTH-1:0] data2_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic                  negate_i,
  input  logic                  imm_sel_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o
);

  logic [DATA_WIDTH-1:0] neg2;
  logic [DATA_WIDTH-1:0] op2;
  logic [DATA_WIDTH-1:0] result;

  // Immediate path bypasses the negator entirely.
  always_comb begin
    neg2 = ~data2_i + DATA_WIDTH'(1);
    op2  = imm_sel_i ? imm_i : (negate_i ? neg2 : data2_i);
  end

  // Reserved and unknown opcodes fall to the default and yield zero.
  always_comb begin
    result = '0;
    case (aluop_i)
      ALU_FWD: result = op2;
      ALU_ADD: result = data1_i + op2;
      ALU_AND: result = data1_i & op2;
      ALU_OR:  result = data1_i | op2;
      default: result = '0;
    endcase
  end

  assign result_o = result;
  assign zero_o   = (result == '0);

endmodule

// File: rtl/alu_pc_exec_unit.sv
// Execute-stage core: program counter register with +PC_STEP incrementer, plus the 8-bit ALU.
module alu_pc_exec_unit
  import cpu_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  alu_pc_exec_unit_if.slave  bus
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  // Hold on PC_WE low covers stalls and busy-wait.
  always_comb begin
    pc_d = pc_q;
    if (bus.PC_WE) pc_d = bus.PC_NEXT;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign bus.PC     = pc_q;
  assign bus.PC_INC = pc_q + PC_WIDTH'(PC_STEP);

  alu8_core u_alu8_core (
    .data1_i   (bus.DATA1),
    .data2_i   (bus.DATA2),
    .imm_i     (bus.IMM),
    .negate_i  (bus.NEGATE),
    .imm_sel_i (bus.IMM_SEL),
    .aluop_i   (bus.ALUOP),
    .result_o  (bus.RESULT),
    .zero_o    (bus.ZERO)
  );

endmodule

// File: tb/tb_alu_pc_exec_unit.sv
// Self-checking bench for alu_pc_exec_unit: directed corner cases then randomized traffic vs a reference model.
module tb_alu_pc_exec_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_pc;

  alu_pc_exec_unit_if bus ();

  alu_pc_exec_unit dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference ALU built from the arithmetic rules with plain integers.
  function automatic int ref_alu(input int d1, input int d2, input int imm,
                                 input bit neg, input bit isel, input int op);
    int op2;
    op2 = isel ? imm : (neg ? (256 - d2) % 256 : d2);
    case (op)
      0:       return op2;
      1:       return (d1 + op2) % 256;
      2:       return d1 & op2;
      3:       return d1 | op2;
      default: return 0;
    endcase
  endfunction

  task automatic alu_check(input string tag, input int d1, input int d2, input int imm,
                           input bit neg, input bit isel, input int op);
    int r;
    bus.DATA1   = 8'(d1);
    bus.DATA2   = 8'(d2);
    bus.IMM     = 8'(imm);
    bus.NEGATE  = neg;
    bus.IMM_SEL = isel;
    bus.ALUOP   = 3'(op);
    #1;
    r = ref_alu(d1, d2, imm, neg, isel, op);
    check({tag, ".result"}, 32'(bus.RESULT), 32'(r));
    check({tag, ".zero"},   32'(bus.ZERO),   32'(r == 0));
  endtask

  // One rising edge, returning at the following falling edge; model follows the load rule.
  task automatic pc_step(input bit we, input logic [31:0] nxt);
    bus.PC_WE   = we;
    bus.PC_NEXT = nxt;
    @(posedge clk);
    if (we) exp_pc = nxt;
    @(negedge clk);
  endtask

  task automatic pc_check(input string tag);
    check({tag, ".pc"},     bus.PC,     exp_pc);
    check({tag, ".pc_inc"}, bus.PC_INC, exp_pc + 32'd4);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    exp_pc   = 32'h0;
    bus.PC_WE = 1'b1; bus.PC_NEXT = 32'hDEAD_BEEF;
    bus.DATA1 = '0; bus.DATA2 = '0; bus.IMM = '0;
    bus.NEGATE = 1'b0; bus.IMM_SEL = 1'b0; bus.ALUOP = '0;

    // Reset holds PC at zero across edges even with PC_WE asserted.
    repeat (2) @(negedge clk);
    pc_check("reset");
    rst_n = 1'b1;

    // Mid-cycle async reset from PC=0x10.
    pc_step(1'b1, 32'h10);
    pc_check("load10");
    #2 rst_n = 1'b0;
    exp_pc = 32'h0;
    #1;
    pc_check("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_step(1'b1, exp_pc + 32'd4);
      pc_check($sformatf("incr%0d", i));
    end

    // Stall from PC=8, then wrap at the top of the address space.
    pc_step(1'b1, 32'h8);
    pc_step(1'b0, 32'h1234_5678);
    pc_step(1'b0, 32'h0000_0040);
    pc_check("stall");
    pc_step(1'b1, 32'hFFFF_FFFC);
    pc_check("wrap");
    check("wrap.pc_inc_zero", bus.PC_INC, 32'h0);

    // Directed ALU corners.
    alu_check("add",      8'h05, 8'h03, 0,     1'b0, 1'b0, 1);
    check("add.const", 32'(bus.RESULT), 32'h08);
    alu_check("add_wrap", 8'hFF, 8'h01, 0,     1'b0, 1'b0, 1);
    check("add_wrap.const", 32'(bus.ZERO), 32'h1);
    alu_check("beq_eq",   8'h07, 8'h07, 0,     1'b1, 1'b0, 1);
    alu_check("sub_neg",  8'h03, 8'h05, 0,     1'b1, 1'b0, 1);
    check("sub_neg.const", 32'(bus.RESULT), 32'hFE);
    alu_check("fwd_imm",  8'h11, 8'h55, 8'h2A, 1'b1, 1'b1, 0);
    check("fwd_imm.const", 32'(bus.RESULT), 32'h2A);
    alu_check("and",      8'hF0, 8'h3C, 0,     1'b0, 1'b0, 2);
    alu_check("or",       8'hF0, 8'h0F, 0,     1'b0, 1'b0, 3);
    alu_check("rsvd101",  8'hA5, 8'h5A, 8'h77, 1'b0, 1'b0, 5);
    alu_check("neg80",    8'h00, 8'h80, 0,     1'b1, 1'b0, 0);
    check("neg80.const", 32'(bus.RESULT), 32'h80);
    alu_check("neg00",    8'h00, 8'h00, 0,     1'b1, 1'b0, 0);

    // Randomized traffic: ALU operands, PC loads/stalls and occasional async resets.
    for (int i = 0; i < 300; i++) begin
      alu_check($sformatf("rnd%0d", i),
                int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)),
                1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(7)));
      if ($urandom_range(19) == 0) begin
        rst_n = 1'b0;
        exp_pc = 32'h0;
        #1;
        pc_check($sformatf("rnd_rst%0d", i));
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        pc_step(1'($urandom_range(1)), $urandom);
        pc_check($sformatf("rnd_pc%0d", i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
